// File: rtl/microwave_door_sequencer.sv
// Door servo sequencer: turns open/close request edges into a per-frame ramped servo duty,
// stops the magnetron before opening and auto-closes after a programmable number of frames.
module microwave_door_sequencer #(
  parameter int PWM_PERIOD        = 2_000_000,
  parameter int DUTY_0_DEG        = 50_000,
  parameter int DUTY_90_DEG       = 150_000,
  parameter int DUTY_STEP         = 5_000,
  parameter int AUTO_CLOSE_FRAMES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        open_req,
  input  logic        close_req,
  input  logic        heating,
  output logic        heat_stop_req,
  output logic        heat_enable,
  output logic [19:0] servo_duty,
  output logic        frame_sync,
  output logic        door_open,
  output logic        busy
);

  localparam int AFC_W = $clog2(AUTO_CLOSE_FRAMES + 1);

  localparam logic [20:0] P_PER  = 21'(PWM_PERIOD);
  localparam logic [20:0] P_D0   = 21'(DUTY_0_DEG);
  localparam logic [20:0] P_D90  = 21'(DUTY_90_DEG);
  localparam logic [20:0] P_STEP = 21'(DUTY_STEP);
  localparam logic [AFC_W-1:0] P_AFC_LAST = AFC_W'(AUTO_CLOSE_FRAMES - 1);

  typedef enum logic [2:0] {
    CLOSED    = 3'd0,
    STOP_HEAT = 3'd1,
    OPENING   = 3'd2,
    OPEN      = 3'd3,
    CLOSING   = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [20:0]      frame_cnt;
  logic [19:0]      duty_n;
  logic [AFC_W-1:0] afc, afc_n;
  logic             open_d, close_d;

  logic        tick;
  logic        open_rise, close_rise, open_acc;
  logic [20:0] duty_ext, duty_up, duty_up_sat, duty_dn_sat;

  assign tick       = (frame_cnt == P_PER);
  assign open_rise  = open_req & ~open_d;
  assign close_rise = close_req & ~close_d;
  // Simultaneous open and close edges resolve to close.
  assign open_acc   = open_rise & ~close_rise;

  // 21-bit intermediate so neither end of the ramp can wrap.
  assign duty_ext    = {1'b0, servo_duty};
  assign duty_up     = duty_ext + P_STEP;
  assign duty_up_sat = (duty_up >= P_D90) ? P_D90 : duty_up;
  assign duty_dn_sat = (duty_ext <= P_D0 + P_STEP) ? P_D0 : (duty_ext - P_STEP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt  <= '0;
      frame_sync <= 1'b0;
    end else begin
      frame_cnt  <= tick ? 21'd0 : frame_cnt + 21'd1;
      frame_sync <= tick;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= CLOSED;
      servo_duty <= P_D0[19:0];
      afc        <= '0;
      open_d     <= 1'b0;
      close_d    <= 1'b0;
    end else begin
      state      <= state_n;
      servo_duty <= duty_n;
      afc        <= afc_n;
      open_d     <= open_req;
      close_d    <= close_req;
    end
  end

  always_comb begin
    state_n = state;
    duty_n  = servo_duty;
    afc_n   = afc;
    case (state)
      CLOSED: begin
        if (open_acc) state_n = heating ? STOP_HEAT : OPENING;
      end
      STOP_HEAT: begin
        if (close_rise)    state_n = CLOSED;
        else if (!heating) state_n = OPENING;
      end
      OPENING: begin
        if (tick) duty_n = duty_up_sat[19:0];
        if (close_rise) begin
          state_n = CLOSING;
        end else if (tick && duty_up_sat == P_D90) begin
          state_n = OPEN;
          afc_n   = '0;
        end
      end
      OPEN: begin
        if (tick)     afc_n = afc + AFC_W'(1);
        if (open_acc) afc_n = '0;
        if (close_rise || (tick && afc == P_AFC_LAST)) state_n = CLOSING;
      end
      CLOSING: begin
        if (tick) duty_n = duty_dn_sat[19:0];
        if (open_acc)                          state_n = OPENING;
        else if (tick && duty_dn_sat == P_D0)  state_n = CLOSED;
      end
      default: state_n = CLOSED;
    endcase
  end

  assign heat_stop_req = (state == STOP_HEAT);
  assign busy          = (state == STOP_HEAT) || (state == OPENING) || (state == CLOSING);
  assign door_open     = (state == OPEN);
  assign heat_enable   = (state == CLOSED) & ~busy;

endmodule

// File: tb/tb_microwave_door_sequencer.sv
// Directed bench for the door sequencer: expected per-frame duty/door/heat values are queued
// as stimulus is applied and checked at each frame_sync pulse.
module tb_microwave_door_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        open_req = 1'b0, close_req = 1'b0, heating = 1'b0;
  logic        heat_stop_req, heat_enable, frame_sync, door_open, busy;
  logic [19:0] servo_duty;

  microwave_door_sequencer #(
    .PWM_PERIOD(99), .DUTY_0_DEG(10), .DUTY_90_DEG(30), .DUTY_STEP(5), .AUTO_CLOSE_FRAMES(3)
  ) dut (
    .clk(clk), .reset(reset), .open_req(open_req), .close_req(close_req), .heating(heating),
    .heat_stop_req(heat_stop_req), .heat_enable(heat_enable), .servo_duty(servo_duty),
    .frame_sync(frame_sync), .door_open(door_open), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int duty; int dopen; int hen; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int last_sync = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input int dopen, input int hen);
    exp_t e;
    e.duty = d; e.dopen = dopen; e.hen = hen;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req(input bit o, input bit c);
    @(negedge clk);
    open_req = o; close_req = c;
    step(2);
    open_req = 1'b0; close_req = 1'b0;
  endtask

  // Wait for each frame_sync and compare against the head of the scoreboard.
  task automatic consume(input int n);
    for (int i = 0; i < n; i++) begin
      int budget;
      exp_t e;
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (frame_sync !== 1'b1 && budget < 300);
      chk("sync_seen", int'(frame_sync === 1'b1), 1);
      if (frame_sync === 1'b1) begin
        chk("frame_period", cyc - last_sync, 100);
        last_sync = cyc;
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("duty", int'(servo_duty), e.duty);
          chk("door_open", int'(door_open), e.dopen);
          chk("heat_enable", int'(heat_enable), e.hen);
        end else begin
          chk("sb_underflow", q.size(), 1);
        end
      end
    end
  endtask

  initial begin
    // 1. reset state and first frame_sync at clk 100
    #12;
    chk("rst_duty", int'(servo_duty), 10);
    chk("rst_heat_en", int'(heat_enable), 1);
    chk("rst_stop_req", int'(heat_stop_req), 0);
    chk("rst_fsync", int'(frame_sync), 0);
    chk("rst_door", int'(door_open), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b1;
    last_sync = cyc;
    push(10, 0, 1); push(10, 0, 1);
    consume(2);

    // 2. open with heater off: ramp to 30 then OPEN
    pulse_req(1'b1, 1'b0);
    chk("open_busy", int'(busy), 1);
    chk("open_heat_en", int'(heat_enable), 0);
    push(15, 0, 0); push(20, 0, 0); push(25, 0, 0); push(30, 1, 0);
    consume(4);

    // 4. auto-close after 3 ticks in OPEN, ramp back down
    push(30, 1, 0); push(30, 1, 0); push(30, 0, 0);
    push(25, 0, 0); push(20, 0, 0); push(15, 0, 0); push(10, 0, 1);
    consume(7);
    chk("closed_busy", int'(busy), 0);

    // 3. open while heating: stop heater first, duty held
    heating = 1'b1;
    pulse_req(1'b1, 1'b0);
    chk("stop_req", int'(heat_stop_req), 1);
    chk("stop_busy", int'(busy), 1);
    push(10, 0, 0); push(10, 0, 0);
    consume(2);
    step(10);
    heating = 1'b0;
    step(2);
    chk("stop_req_drop", int'(heat_stop_req), 0);
    push(15, 0, 0); push(20, 0, 0);
    consume(2);

    // 5. close during OPENING at 20 -> ramp down from current duty
    pulse_req(1'b0, 1'b1);
    push(15, 0, 0); push(10, 0, 1);
    consume(2);
    // simultaneous open+close in CLOSED: close wins
    pulse_req(1'b1, 1'b1);
    chk("both_busy", int'(busy), 0);
    chk("both_heat_en", int'(heat_enable), 1);
    push(10, 0, 1);
    consume(1);

    // 6. async reset mid-ramp at duty 25
    pulse_req(1'b1, 1'b0);
    push(15, 0, 0); push(20, 0, 0); push(25, 0, 0);
    consume(3);
    step(30);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_duty", int'(servo_duty), 10);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_heat_en", int'(heat_enable), 1);
    step(3);
    reset = 1'b1;
    last_sync = cyc;
    push(10, 0, 1);
    consume(1);

    // reversal: close at 20 then reopen during CLOSING
    pulse_req(1'b1, 1'b0);
    push(15, 0, 0); push(20, 0, 0);
    consume(2);
    pulse_req(1'b0, 1'b1);
    push(15, 0, 0);
    consume(1);
    pulse_req(1'b1, 1'b0);
    chk("reopen_busy", int'(busy), 1);
    push(20, 0, 0); push(25, 0, 0); push(30, 1, 0);
    consume(3);

    chk("sb_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
